// File: rtl/cpu_control_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_if
// Control bundle between the multicycle control sequencer and the rest of the
// CPU (instruction register, datapath, shared memory port).
//
// Signals:
//   opcode        IR[15:12], valid from DECODE onward
//   zero          ALU zero flag, sampled in EXECUTE
//   mem_ready     memory completes the current read/write this cycle
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      load IR from memory data
//   pc_write      update PC
//   pc_src        00 PC+2, 01 branch target, 10 jump target
//   reg_write     register file write
//   mem_to_reg    writeback source: 1 memory data, 0 ALU result
//   alu_src_imm   ALU B operand is the immediate
//   alu_op        000 add, 001 sub, 010 R-type, 011 pass
//   halted        sequencer parked in HALT
//   state         current state code (debug)
//   retire_count  retired-instruction counter (only with CTRL_RETIRE_COUNT_EN)
//
// Modports: master = sequencer side, slave = datapath/memory side.
// ---------------------------------------------------------------------------
interface cpu_ctrl_if #(
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNT_W = 16
);
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_imm;
    logic [2:0]       alu_op;
    logic             halted;
    logic [2:0]       state;
`ifdef CTRL_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retire_count;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src_imm, alu_op, halted, state
`ifdef CTRL_RETIRE_COUNT_EN
        , output retire_count
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
               mem_to_reg, alu_src_imm, alu_op, halted, state
`ifdef CTRL_RETIRE_COUNT_EN
        , input retire_count
`endif
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_control_sequencer
// Multicycle control FSM of the 16-bit CPU: FETCH, DECODE, EXECUTE, MEM, WB,
// HALT. Only the state register (and the optional retire counter) is
// sequential; every control output decodes combinationally from the state,
// opcode, zero flag and memory-ready handshake.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   synchronous active-high reset (state -> FETCH, counter -> 0)
//   ctrl    cpu_ctrl_if.master control bundle
//
// Optional feature: define CTRL_RETIRE_COUNT_EN to add ctrl.retire_count,
// a wrapping count of retired instructions.
// ---------------------------------------------------------------------------
module cpu_control_sequencer #(
    parameter int unsigned    OPW     = 4,
    parameter logic [OPW-1:0] HALT_OP = '1,
    parameter int unsigned    CNT_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    cpu_ctrl_if.master  ctrl
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_LW   = OPW'(2);
    localparam logic [OPW-1:0] OP_SW   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);

    state_t state_q, state_d;

    // Opcodes that need an EXECUTE cycle; everything else except JMP/HALT is a NOP.
    function automatic logic is_exec_op(input logic [OPW-1:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ctrl.mem_read    = 1'b0;
        ctrl.mem_write   = 1'b0;
        ctrl.ir_write    = 1'b0;
        ctrl.pc_write    = 1'b0;
        ctrl.pc_src      = 2'b00;
        ctrl.reg_write   = 1'b0;
        ctrl.mem_to_reg  = 1'b0;
        ctrl.alu_src_imm = 1'b0;
        ctrl.alu_op      = 3'b000;
        ctrl.halted      = 1'b0;
        ctrl.state       = state_q;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (ctrl.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                // HALT_OP is tested first so an override onto a used opcode still halts.
                if (ctrl.opcode == HALT_OP) begin
                    state_d = S_HALT;
                end else if (ctrl.opcode == OP_JMP) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = 2'b10;
                    state_d       = S_FETCH;
                end else if (is_exec_op(ctrl.opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (ctrl.opcode)
                    OP_R: begin
                        ctrl.alu_op = 3'b010;
                        state_d     = S_WB;
                    end
                    OP_ADDI: begin
                        ctrl.alu_src_imm = 1'b1;
                        state_d          = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ctrl.alu_src_imm = 1'b1;
                        state_d          = S_MEM;
                    end
                    OP_BEQ: begin
                        ctrl.alu_op = 3'b001;
                        if (ctrl.zero) begin
                            ctrl.pc_write = 1'b1;
                            ctrl.pc_src   = 2'b01;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (ctrl.opcode == OP_SW) begin
                    ctrl.mem_write = 1'b1;
                    if (ctrl.mem_ready) state_d = S_FETCH;
                end else if (ctrl.opcode == OP_LW) begin
                    ctrl.mem_read = 1'b1;
                    if (ctrl.mem_ready) state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (ctrl.opcode == OP_LW);
                state_d         = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: state_d = S_FETCH;   // codes 6/7 recover
        endcase
    end

`ifdef CTRL_RETIRE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    // An instruction retires on the edge leaving its last state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE:  retire = (ctrl.opcode == HALT_OP) || !is_exec_op(ctrl.opcode);
            S_EXECUTE: retire = (ctrl.opcode == OP_BEQ);
            S_MEM:     retire = (ctrl.opcode == OP_SW) && ctrl.mem_ready;
            S_WB:      retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ctrl.retire_count = cnt_q;
`endif
endmodule
